cla_adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output. It is the successor to the fixed 4-group carry logic. Operands are split into GROUP-bit lookahead groups. Stage 1 registers bit and group generate/propagate terms. Stage 2 resolves group carries by lookahead and forms the sum. It serves as the arithmetic datapath element for wider CLA-based units.

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_lookahead_n.sv | 40 ++++
 rtl/cla_adder_pipe.sv | 169 ++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned GROUP_MIN = 2;
  localparam int unsigned GROUP_MAX = 8;

  typedef struct packed {
    logic p;
    logic g;
  } gp_t;

  function automatic int unsigned num_groups(input int unsigned width, input int unsigned group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_lookahead_n.sv
// Combinational N-wide lookahead: every carry and the block P/G are flat sum-of-products terms.
module cla_lookahead_n
  import cla_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  gp_t  [N-1:0] i_gp,
  input  logic         i_c,
  output logic [N:0]   o_c,
  output logic         o_p,
  output logic         o_g
);

  always_comb begin
    logic v_term;
    v_term = 1'b0;
    o_c    = '0;
    o_c[0] = i_c;
    // c[k+1] = p[k:0]&c0 | OR_j g[j]&p[k:j+1], no ripple through earlier carries
    for (int k = 0; k < N; k++) begin
      v_term = i_c;
      for (int m = 0; m <= k; m++) v_term = v_term & i_gp[m].p;
      o_c[k+1] = v_term;
      for (int j = 0; j <= k; j++) begin
        v_term = i_gp[j].g;
        for (int m = j + 1; m <= k; m++) v_term = v_term & i_gp[m].p;
        o_c[k+1] = o_c[k+1] | v_term;
      end
    end
    o_p = 1'b1;
    for (int m = 0; m < N; m++) o_p = o_p & i_gp[m].p;
    o_g = 1'b0;
    for (int j = 0; j < N; j++) begin
      v_term = i_gp[j].g;
      for (int m = j + 1; m < N; m++) v_term = v_term & i_gp[m].p;
      o_g = o_g | v_term;
    end
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready on both sides.
// S1 holds bit and group P/G terms; S2 resolves carries and registers the result.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NG = num_groups(WIDTH, GROUP);

  if (GROUP < GROUP_MIN || GROUP > GROUP_MAX || WIDTH < 4 || (WIDTH % GROUP) != 0)
  begin : g_param_check
    $error("cla_adder_pipe: illegal WIDTH/GROUP combination");
  end

  // Stage 1 combinational terms
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c0;
  gp_t  [WIDTH-1:0]  w_gp;
  logic [NG-1:0]     w_pg;
  logic [NG-1:0]     w_gg;

  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub | cin;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_gp[i].p = a[i] ^ w_b_eff[i];
      w_gp[i].g = a[i] & w_b_eff[i];
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s1_grp
    logic [GROUP:0] w_unused_c;
    cla_lookahead_n #(.N(GROUP)) u_grp_gp (
      .i_gp (w_gp[k*GROUP +: GROUP]),
      .i_c  (1'b0),
      .o_c  (w_unused_c),
      .o_p  (w_pg[k]),
      .o_g  (w_gg[k])
    );
  end

  // Stage registers and handshake
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_p;
  logic [WIDTH-1:0] r_s1_g;
  logic [NG-1:0]    r_s1_pg;
  logic [NG-1:0]    r_s1_gg;
  logic             r_s1_c0;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_adv1;
  logic             w_adv2;

  assign w_adv2   = ~r_s2_valid | out_ready;
  assign w_adv1   = ~r_s1_valid | w_adv2;
  assign in_ready = w_adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s1_g     <= '0;
      r_s1_pg    <= '0;
      r_s1_gg    <= '0;
      r_s1_c0    <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < WIDTH; i++) begin
          r_s1_p[i] <= w_gp[i].p;
          r_s1_g[i] <= w_gp[i].g;
        end
        r_s1_pg <= w_pg;
        r_s1_gg <= w_gg;
        r_s1_c0 <= w_c0;
      end
    end
  end

  // Stage 2 combinational carry resolution
  gp_t  [NG-1:0]    w_grp_gp;
  gp_t  [WIDTH-1:0] w_s1_gp;
  logic [NG:0]      w_gc;
  logic [WIDTH:0]   w_c;
  logic             w_unused_grp_p;
  logic             w_unused_grp_g;
  logic [WIDTH-1:0] w_sum;

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      w_grp_gp[k].p = r_s1_pg[k];
      w_grp_gp[k].g = r_s1_gg[k];
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_s1_gp[i].p = r_s1_p[i];
      w_s1_gp[i].g = r_s1_g[i];
    end
  end

  cla_lookahead_n #(.N(NG)) u_grp_cla (
    .i_gp (w_grp_gp),
    .i_c  (r_s1_c0),
    .o_c  (w_gc),
    .o_p  (w_unused_grp_p),
    .o_g  (w_unused_grp_g)
  );

  for (genvar k = 0; k < NG; k++) begin : g_s2_grp
    logic [GROUP:0] w_cg;
    logic           w_unused_top;
    logic           w_unused_p;
    logic           w_unused_g;
    cla_lookahead_n #(.N(GROUP)) u_bit_cla (
      .i_gp (w_s1_gp[k*GROUP +: GROUP]),
      .i_c  (w_gc[k]),
      .o_c  (w_cg),
      .o_p  (w_unused_p),
      .o_g  (w_unused_g)
    );
    assign w_c[k*GROUP +: GROUP] = w_cg[GROUP-1:0];
    // The group-level lookahead already provides each group's carry-out
    assign w_unused_top = w_cg[GROUP];
  end

  assign w_c[WIDTH] = w_gc[NG];
  assign w_sum      = r_s1_p ^ w_c[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      // Bubbles leave the last result on the outputs
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench: directed cases on an 8/4 instance, then randomized traffic on
// 8/4, 16/4 and 12/3 instances checked against an arithmetic reference model.
module tb_cla_adder_pipe;

  typedef struct {
    longint sum;
    bit     cout;
    bit     ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   dir_done = 1'b0;

  localparam int N8   = 3000;
  localparam int NRND = 10000;

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed overflow from the true signed result
  function automatic exp_t model(input int w, input longint ra, input longint rb,
                                 input bit rc, input bit rs);
    exp_t   e;
    longint one, full, half, sa, sb, sr;
    one  = 1;
    half = one << (w - 1);
    if (rs) full = ra - rb + (one << w);
    else    full = ra + rb + longint'(rc);
    e.sum  = full & ((one << w) - 1);
    e.cout = ((full >> w) & 1) != 0;
    sa = (ra >= half) ? ra - (one << w) : ra;
    sb = (rb >= half) ? rb - (one << w) : rb;
    sr = rs ? sa - sb : sa + sb + longint'(rc);
    e.ovf = (sr >= half) || (sr < -half);
    return e;
  endfunction

  // Mix of uniform adds/subs, forced carry chains of every length, and corner operands
  function automatic void gen_op(input int w, input int idx, output longint ra,
                                 output longint rb, output bit rc, output bit rs);
    longint one, mask, lowm;
    longint ev[4];
    one  = 1;
    mask = (one << w) - 1;
    ev   = '{0, mask, one << (w - 1), (one << (w - 1)) - 1};
    ra   = longint'($urandom) & mask;
    rb   = longint'($urandom) & mask;
    rc   = 1'($urandom_range(0, 1));
    rs   = 1'b0;
    case ($urandom_range(0, 3))
      1: rs = 1'b1;
      2: begin
        lowm = (one << (idx % (w + 1))) - 1;
        rb   = (~ra & lowm) | (longint'($urandom) & mask & ~lowm);
        rc   = 1'b1;
      end
      3: begin
        ra = ev[$urandom_range(0, 3)];
        rb = ev[$urandom_range(0, 3)];
        rs = 1'($urandom_range(0, 1));
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  // 8/4 instance used for directed and random checks
  logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;
  exp_t       q8[$];

  cla_adder_pipe #(.WIDTH(8), .GROUP(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL w8 unexpected result: got sum 0x%0h, required no result", sum);
      end else begin
        e = q8.pop_front();
        check("w8 sum", 64'(sum), e.sum);
        check("w8 cout", 64'(cout), 64'(e.cout));
        check("w8 ovf", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accepting edge
  task automatic send8(input logic [7:0] oa, input logic [7:0] ob, input bit oc, input bit os,
                       input longint es, input bit ec, input bit eo);
    exp_t e;
    int   k;
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL w8 accept timeout: got in_ready 0, required 1");
    end else begin
      e.sum = es; e.cout = ec; e.ovf = eo;
      q8.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wider configurations: randomized traffic only
  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 16 : 12;
    localparam int G = (gi == 0) ? 4 : 3;
    logic         g_in_valid, g_in_ready, g_cin, g_sub, g_out_valid, g_out_ready, g_cout, g_ovf;
    logic [W-1:0] g_a, g_b, g_sum;
    exp_t         gq[$];
    bit           done = 1'b0;

    cla_adder_pipe #(.WIDTH(W), .GROUP(G)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (g_in_valid),
      .in_ready  (g_in_ready),
      .a         (g_a),
      .b         (g_b),
      .cin       (g_cin),
      .sub       (g_sub),
      .out_valid (g_out_valid),
      .out_ready (g_out_ready),
      .sum       (g_sum),
      .cout      (g_cout),
      .ovf       (g_ovf)
    );

    always @(negedge clk) begin
      exp_t e;
      if (rst_n && g_out_valid && g_out_ready) begin
        if (gq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL w%0d unexpected result: got sum 0x%0h, required no result", W, g_sum);
        end else begin
          e = gq.pop_front();
          check($sformatf("w%0d sum", W), 64'(g_sum), e.sum);
          check($sformatf("w%0d cout", W), 64'(g_cout), 64'(e.cout));
          check($sformatf("w%0d ovf", W), 64'(g_ovf), 64'(e.ovf));
        end
      end
    end

    initial begin
      int     sent, cyc;
      bit     pend, acc, rc, rs;
      longint ra, rb;
      g_in_valid = 1'b0; g_out_ready = 1'b1;
      g_a = '0; g_b = '0; g_cin = 1'b0; g_sub = 1'b0;
      sent = 0; cyc = 0; pend = 1'b0; acc = 1'b0;
      ra = 0; rb = 0; rc = 1'b0; rs = 1'b0;
      wait (dir_done);
      while (sent < NRND && cyc < NRND * 20) begin
        @(posedge clk);
        #1 cyc++;
        if (acc) begin
          pend = 1'b0;
          g_in_valid = 1'b0;
        end
        g_out_ready = ($urandom_range(0, 3) != 0);
        if (!pend && $urandom_range(0, 7) != 0) begin
          gen_op(W, sent, ra, rb, rc, rs);
          g_a = ra[W-1:0]; g_b = rb[W-1:0]; g_cin = rc; g_sub = rs;
          g_in_valid = 1'b1;
          pend = 1'b1;
        end
        @(negedge clk);
        acc = g_in_valid && g_in_ready;
        if (acc) begin
          gq.push_back(model(W, ra, rb, rc, rs));
          sent++;
        end
      end
      @(posedge clk);
      #1 g_in_valid = 1'b0;
      g_out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 check($sformatf("w%0d ops issued", W), 64'(sent), 64'(NRND));
      check($sformatf("w%0d drain queue", W), 64'(gq.size()), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    int     sent, cyc, t;
    bit     pend, acc, rc, rs;
    longint ra, rb;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sent = 0; cyc = 0; pend = 1'b0; acc = 1'b0;
    ra = 0; rb = 0; rc = 1'b0; rs = 1'b0;

    #1 rst_n = 1'b0;
    #11;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("after reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Latency: valid two edges after the operands are presented
    send8(8'hFF, 8'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("latency out_valid after 1 edge", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency out_valid after 2 edges", 64'(out_valid), 64'd1);
    check("latency sum", 64'(sum), 64'h00);
    @(posedge clk);
    #1;

    // Add overflow, carry-in, subtraction with cin ignored; back-to-back
    send8(8'h7F, 8'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);
    send8(8'h10, 8'h0F, 1'b1, 1'b0, 64'h20, 1'b0, 1'b0);
    send8(8'h05, 8'h07, 1'b1, 1'b1, 64'hFE, 1'b0, 1'b0);
    send8(8'h80, 8'h01, 1'b1, 1'b1, 64'h7F, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1 check("directed drain", 64'(q8.size()), 64'd0);

    // Backpressure: two accepts, then stall with outputs frozen
    out_ready = 1'b0;
    send8(8'h01, 8'h01, 1'b0, 1'b0, 64'h02, 1'b0, 1'b0);
    send8(8'h02, 8'h02, 1'b0, 1'b0, 64'h04, 1'b0, 1'b0);
    a = 8'h03; b = 8'h03; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall in_ready", 64'(in_ready), 64'd0);
      check("stall out_valid", 64'(out_valid), 64'd1);
      check("stall sum held", 64'(sum), 64'h02);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release in_ready", 64'(in_ready), 64'd1);
    begin
      exp_t e;
      e.sum = 64'h06; e.cout = 1'b0; e.ovf = 1'b0;
      if (in_ready) q8.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("backpressure drain", 64'(q8.size()), 64'd0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    send8(8'h11, 8'h22, 1'b0, 1'b0, 64'h33, 1'b0, 1'b0);
    send8(8'h01, 8'h02, 1'b0, 1'b0, 64'h03, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset sum", 64'(sum), 64'd0);
    check("async reset cout", 64'(cout), 64'd0);
    check("async reset ovf", 64'(ovf), 64'd0);
    q8.delete();
    out_ready = 1'b1;
    #10 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post reset out_valid", 64'(out_valid), 64'd0);
      check("post reset in_ready", 64'(in_ready), 64'd1);
    end
    dir_done = 1'b1;

    // Randomized traffic with random backpressure on the 8/4 instance
    while (sent < N8 && cyc < N8 * 20) begin
      @(posedge clk);
      #1 cyc++;
      if (acc) begin
        pend = 1'b0;
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 7) != 0) begin
        gen_op(8, sent, ra, rb, rc, rs);
        a = ra[7:0]; b = rb[7:0]; cin = rc; sub = rs;
        in_valid = 1'b1;
        pend = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        q8.push_back(model(8, ra, rb, rc, rs));
        sent++;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("w8 ops issued", 64'(sent), 64'(N8));
    check("w8 drain queue", 64'(q8.size()), 64'd0);

    t = 0;
    while (!(g_cfg[0].done && g_cfg[1].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (!(g_cfg[0].done && g_cfg[1].done)) begin
      n_cmp++;
      n_err++;
      $display("FAIL random run timeout: got unfinished after %0d cycles, required done", t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
